// File: rtl/alu_result_checker.sv
// Pass/fail monitor for the 4-bit ALU: recomputes each applied result,
// counts matches and mismatches, captures the first mismatch, reports at end.
module alu_result_checker #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             done,
  input  logic             in_valid,
  input  logic [3:0]       A,
  input  logic [3:0]       B,
  input  logic [3:0]       Sel,
  input  logic [7:0]       C,
  output logic             busy,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             err,
  output logic [3:0]       err_A,
  output logic [3:0]       err_B,
  output logic [3:0]       err_Sel,
  output logic [7:0]       err_C,
  output logic [7:0]       err_exp,
  output logic             report_valid
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    REPORT
  } state_t;

  state_t state, state_nx;

  logic       s1_v;
  logic [3:0] s1_A, s1_B, s1_Sel;
  logic [7:0] s1_C, s1_exp;
  logic       accept, hit, match;

  function automatic logic [7:0] ref_res(
    input logic [3:0] a,
    input logic [3:0] b,
    input logic [3:0] sel
  );
    logic [7:0] ax, bx, r;
    ax = {4'b0, a};
    bx = {4'b0, b};
    case (sel)
      4'b0000: r = ax + bx;
      4'b1111: r = ax - bx;
      4'b0001: r = ax & bx;
      4'b0010: r = ax | bx;
      4'b0100: r = ax ^ bx;
      4'b1000: r = {7'b0, a == b};
      4'b0011: r = {7'b0, a > b};
      4'b0110: r = ax << b;
      4'b1100: r = ax >> b;
      4'b0101: r = ax * bx;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (start) begin
      state_nx = RUN;
    end else begin
      case (state)
        RUN:     if (done) state_nx = DRAIN;
        DRAIN:   state_nx = REPORT;
        REPORT:  state_nx = IDLE;
        default: state_nx = state;
      endcase
    end
  end

  // a sample presented alongside start belongs to the old run
  assign accept = (state == RUN) && in_valid && !start;
  assign hit    = s1_v && !start;
  assign match  = (s1_C == s1_exp);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_v   <= 1'b0;
      s1_A   <= '0;
      s1_B   <= '0;
      s1_Sel <= '0;
      s1_C   <= '0;
      s1_exp <= '0;
    end else begin
      s1_v <= accept;
      if (accept) begin
        s1_A   <= A;
        s1_B   <= B;
        s1_Sel <= Sel;
        s1_C   <= C;
        s1_exp <= ref_res(A, B, Sel);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || start) begin
      pass_cnt <= '0;
      fail_cnt <= '0;
      err      <= 1'b0;
      err_A    <= '0;
      err_B    <= '0;
      err_Sel  <= '0;
      err_C    <= '0;
      err_exp  <= '0;
    end else if (hit) begin
      if (match) begin
        if (pass_cnt != '1) pass_cnt <= pass_cnt + CNT_W'(1);
      end else begin
        if (fail_cnt != '1) fail_cnt <= fail_cnt + CNT_W'(1);
        if (!err) begin
          err     <= 1'b1;
          err_A   <= s1_A;
          err_B   <= s1_B;
          err_Sel <= s1_Sel;
          err_C   <= s1_C;
          err_exp <= s1_exp;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy         <= 1'b0;
      report_valid <= 1'b0;
    end else begin
      busy         <= (state_nx == RUN) || (state_nx == DRAIN);
      report_valid <= (state_nx == REPORT);
    end
  end

endmodule

// File: tb/tb_alu_result_checker.sv
// Directed bench for alu_result_checker; a second instance with 3-bit
// counters shares the stimulus to exercise saturation.
module tb_alu_result_checker;

  logic        clk = 1'b0;
  logic        rst_n, start, done, in_valid;
  logic [3:0]  A, B, Sel;
  logic [7:0]  C;
  logic        busy, err, report_valid;
  logic [15:0] pass_cnt, fail_cnt;
  logic [3:0]  err_A, err_B, err_Sel;
  logic [7:0]  err_C, err_exp;

  logic        busy3, err3, rv3;
  logic [2:0]  pass3, fail3;
  logic [3:0]  eA3, eB3, eS3;
  logic [7:0]  eC3, eE3;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_result_checker #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .done(done),
    .in_valid(in_valid), .A(A), .B(B), .Sel(Sel), .C(C),
    .busy(busy), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
    .err(err), .err_A(err_A), .err_B(err_B), .err_Sel(err_Sel),
    .err_C(err_C), .err_exp(err_exp), .report_valid(report_valid)
  );

  alu_result_checker #(.CNT_W(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start), .done(done),
    .in_valid(in_valid), .A(A), .B(B), .Sel(Sel), .C(C),
    .busy(busy3), .pass_cnt(pass3), .fail_cnt(fail3),
    .err(err3), .err_A(eA3), .err_B(eB3), .err_Sel(eS3),
    .err_C(eC3), .err_exp(eE3), .report_valid(rv3)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp(input logic [3:0] s, input logic [3:0] a,
                     input logic [3:0] b, input logic [7:0] c);
    in_valid = 1'b1;
    Sel = s; A = a; B = b; C = c;
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  logic [3:0] gs [12] = '{4'h0, 4'hF, 4'h1, 4'h2, 4'h4, 4'h8,
                          4'h8, 4'h3, 4'h3, 4'h6, 4'hC, 4'h5};
  logic [3:0] ga [12] = '{4'h2, 4'h2, 4'hE, 4'hE, 4'hF, 4'h9,
                          4'h9, 4'hF, 4'h7, 4'h8, 4'h2, 4'hB};
  logic [3:0] gb [12] = '{4'h8, 4'h8, 4'h1, 4'h1, 4'h5, 4'h9,
                          4'h5, 4'h7, 4'hF, 4'h7, 4'h1, 4'h7};
  logic [7:0] gc [12] = '{8'h0A, 8'hFA, 8'h00, 8'h0F, 8'h0A, 8'h01,
                          8'h00, 8'h01, 8'h00, 8'h00, 8'h01, 8'h4D};

  initial begin
    rst_n = 1'b0; start = 1'b0; done = 1'b0; in_valid = 1'b0;
    A = '0; B = '0; Sel = '0; C = '0;
    cyc(); cyc();
    chk("rst_pass", pass_cnt, 0);
    chk("rst_fail", fail_cnt, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rv", report_valid, 0);
    rst_n = 1'b1;

    // golden set
    do_start();
    chk("start_busy", busy, 1);
    for (int i = 0; i < 12; i++) begin
      smp(gs[i], ga[i], gb[i], gc[i]);
      if (i == 1) chk("lat_pass", pass_cnt, 1);
    end
    done = 1'b1;
    cyc();
    done = 1'b0;
    chk("drain_rv", report_valid, 0);
    chk("drain_busy", busy, 1);
    cyc();
    chk("gold_rv", report_valid, 1);
    chk("gold_pass", pass_cnt, 12);
    chk("gold_fail", fail_cnt, 0);
    chk("gold_err", err, 0);
    cyc();
    chk("idle_rv", report_valid, 0);
    chk("idle_busy", busy, 0);

    // fault capture: MUL wrong, then a later SUB wrong
    do_start();
    for (int i = 0; i < 12; i++)
      smp(gs[i], ga[i], gb[i], (i == 11) ? 8'h4C : gc[i]);
    smp(4'hF, 4'h2, 4'h8, 8'h06);
    done = 1'b1;
    cyc();
    done = 1'b0;
    cyc();
    chk("flt_rv", report_valid, 1);
    chk("flt_pass", pass_cnt, 11);
    chk("flt_fail", fail_cnt, 2);
    chk("flt_err", err, 1);
    chk("flt_sel", err_Sel, 4'h5);
    chk("flt_a", err_A, 4'hB);
    chk("flt_b", err_B, 4'h7);
    chk("flt_c", err_C, 8'h4C);
    chk("flt_exp", err_exp, 8'h4D);
    cyc();

    // unused opcode, sample with done, samples after done
    do_start();
    smp(4'hA, 4'h3, 4'h4, 8'h00);
    smp(4'hA, 4'h3, 4'h4, 8'h01);
    done = 1'b1;
    smp(4'h0, 4'h1, 4'h1, 8'h02);
    done = 1'b0;
    smp(4'h0, 4'h1, 4'h1, 8'h02);
    chk("unu_rv", report_valid, 1);
    chk("unu_pass", pass_cnt, 2);
    chk("unu_fail", fail_cnt, 1);
    chk("unu_sel", err_Sel, 4'hA);
    chk("unu_exp", err_exp, 8'h00);
    smp(4'h0, 4'h1, 4'h1, 8'h03);
    smp(4'h0, 4'h1, 4'h1, 8'h03);
    cyc(); cyc();
    chk("ign_pass", pass_cnt, 2);
    chk("ign_fail", fail_cnt, 1);
    chk("ign_busy", busy, 0);

    // start during RUN with a failing sample in flight
    do_start();
    smp(4'h0, 4'h1, 4'h2, 8'h03);
    smp(4'h0, 4'h1, 4'h2, 8'h03);
    smp(4'h0, 4'h1, 4'h2, 8'h55);
    do_start();
    chk("rs_pass0", pass_cnt, 0);
    chk("rs_fail0", fail_cnt, 0);
    chk("rs_busy", busy, 1);
    cyc();
    chk("rs_fail1", fail_cnt, 0);
    chk("rs_err1", err, 0);

    // saturation
    for (int i = 0; i < 10; i++)
      smp(4'h5, 4'h3, 4'h3, 8'h09);
    cyc(); cyc();
    chk("sat3_pass", pass3, 3'd7);
    chk("sat16_pass", pass_cnt, 10);
    chk("sat3_fail", fail3, 3'd0);

    // reset mid-run after three failures
    for (int i = 0; i < 3; i++)
      smp(4'h1, 4'hF, 4'h0, 8'hFF);
    cyc(); cyc();
    chk("pre_fail", fail_cnt, 3);
    chk("pre_err", err, 1);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    chk("mr_pass", pass_cnt, 0);
    chk("mr_fail", fail_cnt, 0);
    chk("mr_err", err, 0);
    chk("mr_errc", err_C, 0);
    chk("mr_busy", busy, 0);
    smp(4'h0, 4'h1, 4'h1, 8'h02);
    smp(4'h0, 4'h1, 4'h1, 8'h02);
    cyc(); cyc();
    chk("mr_ign", pass_cnt, 0);
    chk("mr_ign_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_result_checker.md
# alu_result_checker

Self-checking monitor for the 4-bit `_ALU`, facing the opposite direction from the stimulus driver. The driver applies operands and reads results. This block instead consumes each applied {A, B, Sel} together with the observed C, and recomputes the expected 8-bit result from a registered reference model. It counts passes and failures, latches the first mismatch for debug, and emits a one-cycle end-of-run report. It sits beside the ALU in simulation and FPGA self-test builds, with the driver's outputs fanned out to both.

## Interface
- CNT_W, 16, width of the pass/fail counters
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- start  input  1  pulse: clear counters and error capture, enter RUN
- done  input  1  pulse: end of stimulus, drain and report
- in_valid  input  1  {A, B, Sel, C} valid this cycle
- A  input  4  operand A applied to ALU
- B  input  4  operand B applied to ALU
- Sel  input  4  opcode applied to ALU
- C  input  8  result observed from ALU
- busy  output  1  high in RUN or DRAIN
- pass_cnt  output  CNT_W  matching samples
- fail_cnt  output  CNT_W  mismatching samples
- err  output  1  sticky: at least one mismatch since start
- err_A, err_B, err_Sel  output  4 each  operands of first mismatch
- err_C, err_exp  output  8 each  observed and expected values of first mismatch
- report_valid  output  1  one-cycle pulse; counters and err_* final

## Operation
- States:
  - IDLE: samples ignored.
  - RUN: samples accepted.
  - DRAIN: samples ignored; in-flight sample retires.
  - REPORT: report_valid = 1.
- Transitions:
  - IDLE -start-> RUN.
  - RUN -done-> DRAIN.
  - DRAIN -> REPORT, unconditional after 1 cycle.
  - REPORT -> IDLE, unconditional after 1 cycle.
  - start in any non-reset state: clears counters, err, err_* and the pipeline, then enters RUN. start has priority over done.
- Expected model. Operands are zero-extended to 8 bits; every result is taken mod 256.
  - 0000 SUM: A+B.
  - 1111 SUB: A−B, two's complement (2−8 = 8'hFA).
  - 0001 AND, 0010 OR, 0100 XOR: bitwise, upper nibble 0.
  - 1000 EQ: 8'd1 if A==B, else 0.
  - 0011 GT: unsigned, 8'd1 if A>B, else 0.
  - 0110 SHL: A<<B, logical.
  - 1100 SHR: A>>B, logical.
  - 0101 MUL: A*B.
  - Any other Sel: expected 8'h00.
- Compare is an exact 8-bit equality of C against the expected value.
- Counters saturate at all-ones and never wrap. A saturated counter keeps err and capture behaviour intact.
- err_* load only on the first mismatch after start (err 0→1). Later mismatches only increment fail_cnt.
- A sample with in_valid and done in the same RUN cycle is accepted and counted.

## Timing
- Reset (rst_n low at a rising edge): state IDLE, pipeline valid bits cleared. All outputs read 0, including pass_cnt, fail_cnt, err, err_*, busy and report_valid.
- Reset mid-run discards in-flight samples and counts.
- Pipeline: 2 stages.
  - Stage 1: sample registered at the end of cycle t together with its expected value.
  - Stage 2: compare and counter update at the end of t+1.
  - Counters and err_* reflect sample t in cycle t+2. Throughput is 1 sample per cycle.
- done accepted in cycle d:
  - DRAIN in d+1; the last sample retires at the end of d+1.
  - REPORT in d+2, with report_valid high for exactly that cycle.
  - IDLE in d+3.
- busy is a registered decode of state: high in RUN and DRAIN cycles.
- start in cycle s:
  - Counters read 0 in s+1.
  - First countable sample is in cycle s+1.
  - A stage-1 sample in flight during cycle s is discarded.
- done outside RUN is ignored. in_valid outside RUN is ignored.

## Test plan
- Directed golden set: start, then one sample per cycle, all with correct C:
  - SUM 2+8 = 0A; SUB 2−8 = FA; AND E&1 = 00; OR E|1 = 0F; XOR F^5 = 0A.
  - EQ 9,9 = 01; EQ 9,5 = 00; GT F,7 = 01; GT 7,F = 00.
  - SHL 8<<7 = 00; SHR 2>>1 = 01; MUL B*7 = 4D.
  - Then done. Required: report_valid exactly 2 cycles after done, pass_cnt = 12, fail_cnt = 0, err = 0.
- Fault capture: same set, but MUL drives C = 4C, and later SUB drives C = 06. Required: fail_cnt = 2, err = 1, err_Sel = 0101, err_A = B, err_B = 7, err_C = 4C, err_exp = 4D.
- Unused opcode: Sel = 1010 with C = 00 → pass; Sel = 1010 with C = 01 → fail.
- Boundaries:
  - in_valid with done in the same cycle is counted.
  - in_valid during DRAIN, REPORT or IDLE is not counted.
  - start during RUN with a sample in flight: counters read 0 the next cycle and the in-flight sample is never counted.
- Saturation: CNT_W = 3, 10 passing samples. Required: pass_cnt holds 7.
- Reset mid-run: rst_n low for 1 cycle after 3 failures. Required: all outputs 0 the next cycle, and state IDLE, so subsequent samples are ignored until start.
